// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_access_ctrl_pkg : shared state encodings and byte-enable masks   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_REQ  = 2'd1,
    MAC_RESP = 2'd2
  } mac_state_e;

  localparam logic [3:0] BE_B0  = 4'b0001;
  localparam logic [3:0] BE_B1  = 4'b0010;
  localparam logic [3:0] BE_B2  = 4'b0100;
  localparam logic [3:0] BE_B3  = 4'b1000;
  localparam logic [3:0] BE_HLO = 4'b0011;
  localparam logic [3:0] BE_HHI = 4'b1100;
  localparam logic [3:0] BE_W   = 4'b1111;

  // Zero-extension mask for a load result once shifted down to bit 0.
  function automatic logic [31:0] be_width_mask(input logic [3:0] be);
    logic [31:0] m;
    case (be)
      BE_W:           m = 32'hFFFF_FFFF;
      BE_HLO, BE_HHI: m = 32'h0000_FFFF;
      default:        m = 32'h0000_00FF;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_be_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_be_check : byte-enable legality and alignment checker            |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module mem_be_check
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0] addr_i,
  input  logic [3:0] be_i,
  output logic       legal_o
);

  always_comb begin
    legal_o = 1'b0;
    case (be_i)
      BE_B0:  legal_o = (addr_i == 2'd0);
      BE_B1:  legal_o = (addr_i == 2'd1);
      BE_B2:  legal_o = (addr_i == 2'd2);
      BE_B3:  legal_o = (addr_i == 2'd3);
      BE_HLO: legal_o = (addr_i == 2'd0);
      BE_HHI: legal_o = (addr_i == 2'd2);
      BE_W:   legal_o = (addr_i == 2'd0);
      default: legal_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_access_ctrl : single-outstanding data-memory access sequencer    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEMaddr,
  input  logic [3:0]  MEMrden,
  input  logic [3:0]  MEMwren,
  input  logic [31:0] MEMwrdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_vld,
  output logic        error
);

  mac_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [1:0]        off_q, off_d;
  logic              stall_q, stall_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic              ld_vld_q, ld_vld_d;
  logic              error_q, error_d;

  logic              is_rd, is_wr, mask_legal, cmd_ok;
  logic [3:0]        cmd_mask;
  logic [31:0]       rdata_ext;

  assign is_rd    = |MEMrden;
  assign is_wr    = |MEMwren;
  assign cmd_mask = is_rd ? MEMrden : MEMwren;
  assign cmd_ok   = (is_rd ^ is_wr) & mask_legal;

  mem_be_check u_be_check (
    .addr_i  (MEMaddr[1:0]),
    .be_i    (cmd_mask),
    .legal_o (mask_legal)
  );

  assign rdata_ext = (bus_rdata >> {off_q, 3'b000}) & be_width_mask(bus_be_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    off_d       = off_q;
    stall_d     = stall_q;
    ld_data_d   = ld_data_q;
    ld_vld_d    = 1'b0;
    error_d     = error_q;

    case (state_q)
      MAC_IDLE: begin
        cnt_d = '0;
        if (is_rd || is_wr) begin
          if (cmd_ok) begin
            bus_we_d    = is_wr;
            bus_addr_d  = {MEMaddr[31:2], 2'b00};
            bus_be_d    = cmd_mask;
            bus_wdata_d = MEMwrdata;
            off_d       = MEMaddr[1:0];
            bus_req_d   = 1'b1;
            stall_d     = 1'b1;
            state_d     = MAC_REQ;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      MAC_REQ: begin
        // An ack arriving on the final allowed cycle still counts as success.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = MAC_RESP;
          if (!bus_we_q) begin
            ld_data_d = rdata_ext;
            ld_vld_d  = 1'b1;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          error_d   = 1'b1;
          bus_req_d = 1'b0;
          state_d   = MAC_RESP;
          if (!bus_we_q) begin
            ld_data_d = '0;
            ld_vld_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      MAC_RESP: begin
        cnt_d   = '0;
        stall_d = 1'b0;
        state_d = MAC_IDLE;
      end

      default: begin
        state_d   = MAC_IDLE;
        bus_req_d = 1'b0;
        stall_d   = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MAC_IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      off_q       <= '0;
      stall_q     <= 1'b0;
      ld_data_q   <= '0;
      ld_vld_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      off_q       <= off_d;
      stall_q     <= stall_d;
      ld_data_q   <= ld_data_d;
      ld_vld_q    <= ld_vld_d;
      error_q     <= error_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign stall     = stall_q;
  assign ld_data   = ld_data_q;
  assign ld_vld    = ld_vld_q;
  assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_access_ctrl : randomized self-checking bench for the MEM ctrl |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] MEMaddr;
  logic [3:0]  MEMrden;
  logic [3:0]  MEMwren;
  logic [31:0] MEMwrdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_vld;
  logic        error;

  int n_chk  = 0;
  int n_pass = 0;
  bit exp_err = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .MEMaddr   (MEMaddr),
    .MEMrden   (MEMrden),
    .MEMwren   (MEMwren),
    .MEMwrdata (MEMwrdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .stall     (stall),
    .ld_data   (ld_data),
    .ld_vld    (ld_vld),
    .error     (error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference legality: one direction only, contiguous naturally aligned
  // run of 1, 2 or 4 bytes whose lowest byte equals the address offset.
  function automatic bit model_legal(input logic [3:0] rd, input logic [3:0] wr, input logic [1:0] off);
    logic [3:0] m;
    int size, lo;
    if ((rd != 0) == (wr != 0)) return 1'b0;
    m    = rd | wr;
    size = $countones(m);
    if (!(size == 1 || size == 2 || size == 4)) return 1'b0;
    lo = 0;
    while (m[lo] == 1'b0) lo++;
    if (int'(m) != (((1 << size) - 1) << lo)) return 1'b0;
    if ((lo % size) != 0) return 1'b0;
    return (int'(off) == lo);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [3:0] m, input logic [1:0] off);
    longint unsigned v, msk;
    v   = longint'(rdata) >> (8 * int'(off));
    msk = (64'd1 << (8 * $countones(m))) - 64'd1;
    return 32'(v & msk);
  endfunction

  // Entered and left at a falling edge of an IDLE cycle. ack_at is the
  // 1-based REQ cycle that sees bus_ack; anything outside 1..TO never acks.
  task automatic run_cmd(input logic [3:0] rd, input logic [3:0] wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int ack_at, input logic [31:0] rdata);
    bit legal, is_rd, timed_out;
    int last, stall_hi;
    legal = model_legal(rd, wr, addr[1:0]);
    is_rd = (rd != 0);
    bus_ack = 1'b0;
    MEMrden = rd; MEMwren = wr; MEMaddr = addr; MEMwrdata = wd;
    @(negedge clk);
    MEMrden = '0; MEMwren = '0; MEMaddr = $urandom; MEMwrdata = $urandom;
    if (!legal) begin
      exp_err = 1'b1;
      check_eq("ill_req", 32'(bus_req), 32'd0);
      check_eq("ill_stall", 32'(stall), 32'd0);
      check_eq("ill_err", 32'(error), 32'd1);
      bus_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus_ack = 1'b0;
      check_eq("ill_req2", 32'(bus_req), 32'd0);
      check_eq("ill_vld", 32'(ld_vld), 32'd0);
      return;
    end
    timed_out = !(ack_at >= 1 && ack_at <= TO);
    last = timed_out ? TO : ack_at;
    stall_hi = 0;
    for (int c = 1; c <= last; c++) begin
      check_eq("req_hi", 32'(bus_req), 32'd1);
      if (stall) stall_hi++;
      if (c == 1) begin
        check_eq("bus_addr", bus_addr, {addr[31:2], 2'b00});
        check_eq("bus_we", 32'(bus_we), 32'(wr != 0));
        check_eq("bus_be", 32'(bus_be), 32'(rd | wr));
        if (wr != 0) check_eq("bus_wdata", bus_wdata, wd);
      end
      if (c == ack_at) begin bus_ack = 1'b1; bus_rdata = rdata; end
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = $urandom;
    end
    if (timed_out) exp_err = 1'b1;
    check_eq("resp_req", 32'(bus_req), 32'd0);
    check_eq("resp_vld", 32'(ld_vld), 32'(is_rd));
    if (is_rd) check_eq("ld_data", ld_data, timed_out ? 32'd0 : model_load(rdata, rd, addr[1:0]));
    check_eq("resp_err", 32'(error), 32'(exp_err));
    if (stall) stall_hi++;
    check_eq("stall_len", 32'(stall_hi), 32'(last + 1));
    bus_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus_ack = 1'b0;
    check_eq("idle_stall", 32'(stall), 32'd0);
    check_eq("idle_vld", 32'(ld_vld), 32'd0);
    check_eq("idle_req", 32'(bus_req), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0;
  endtask

  logic [3:0] legal_masks [7];

  initial begin
    legal_masks = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    MEMaddr = '0; MEMrden = '0; MEMwren = '0; MEMwrdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    @(negedge clk);
    do_reset();
    check_eq("rst_req", 32'(bus_req), 32'd0);
    check_eq("rst_we", 32'(bus_we), 32'd0);
    check_eq("rst_addr", bus_addr, 32'd0);
    check_eq("rst_be", 32'(bus_be), 32'd0);
    check_eq("rst_wdata", bus_wdata, 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_ld_data", ld_data, 32'd0);
    check_eq("rst_vld", 32'(ld_vld), 32'd0);
    check_eq("rst_err", 32'(error), 32'd0);

    run_cmd(4'b1111, 4'b0000, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    run_cmd(4'b0100, 4'b0000, 32'h202, 32'h0, 1, 32'h11223344);
    run_cmd(4'b0000, 4'b1111, 32'h40, 32'hCAFEF00D, 1, 32'h0);
    run_cmd(4'b1100, 4'b0000, 32'h302, 32'h0, 2, 32'hA1B2C3D4);
    run_cmd(4'b0000, 4'b1111, 32'h42, 32'h12345678, 1, 32'h0);
    run_cmd(4'b0110, 4'b0000, 32'h50, 32'h0, 1, 32'h0);
    run_cmd(4'b0100, 4'b0000, 32'h203, 32'h0, 1, 32'h0);

    do_reset();
    run_cmd(4'b0001, 4'b0000, 32'h80, 32'h0, 0, 32'h55);
    run_cmd(4'b0000, 4'b0011, 32'h84, 32'hBEEF, 4, 32'h0);

    // Reset landing on the second REQ cycle must abort the access cleanly.
    MEMrden = 4'b1111; MEMaddr = 32'h500;
    @(negedge clk);
    MEMrden = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; exp_err = 1'b0;
    check_eq("mid_rst_req", 32'(bus_req), 32'd0);
    check_eq("mid_rst_stall", 32'(stall), 32'd0);
    check_eq("mid_rst_err", 32'(error), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    check_eq("late_ack_vld", 32'(ld_vld), 32'd0);
    @(negedge clk);
    check_eq("late_ack_vld2", 32'(ld_vld), 32'd0);
    check_eq("late_ack_req", 32'(bus_req), 32'd0);

    for (int i = 0; i < 60; i++) begin
      logic [3:0]  m, rd, wr;
      logic [31:0] a;
      int lo;
      if ($urandom_range(0, 3) == 0) m = 4'($urandom_range(1, 15));
      else m = legal_masks[$urandom_range(0, 6)];
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        lo = 0;
        while (m[lo] == 1'b0) lo++;
        a[1:0] = 2'(lo);
      end
      case ($urandom_range(0, 9))
        0:       begin rd = m; wr = m; end
        1, 2, 3: begin rd = 4'd0; wr = m; end
        default: begin rd = m; wr = 4'd0; end
      endcase
      run_cmd(rd, wr, a, $urandom, $urandom_range(0, 5), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
